irrigation_scheduler: RTL and testbench
=======================================

# irrigation_scheduler

Central sequencer for the irrigation controller. Shares the single tank supply between the drip (gotejamento) and sprinkler (aspersão) requesters with round-robin fairness. Drives the fill valve when the tank is low, and runs a flush/cleaning phase after fertilized sprinkler runs. It sits between the user request inputs, the tank level counter and the irrigation FSM/display logic, and drives the 2-bit irrigation code those blocks consume.

## Interface
- `LEVEL_W`, 3: width of tank level input.
- `MIN_LEVEL`, 1: lowest level at which a run may start or continue.
- `FULL_LEVEL`, 7: level at which filling stops.
- `MAX_RUN`, 15: grant cycles before rotation when the other requester is pending (1..255).
- `FILL_TIMEOUT`, 31: fill cycles allowed before fault (1..255).
- `CLEAN_CYCLES`, 4: length of cleaning phase (1..255).
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_asp` in 1: sprinkler request, level-sensitive.
- `req_got` in 1: drip request, level-sensitive.
- `req_adb` in 1: fertilizer requested with sprinkler; sampled only while the sprinkler is granted.
- `nivel` in LEVEL_W: current tank level, unsigned.
- `rega` out 2: granted irrigation. Encoding: 00 none, 01 drip, 10 sprinkler. 11 is never driven.
- `VE` out 1: fill/flush valve open.
- `limpeza` out 2: cleaning status. Encoding: 00 idle, 10 cleaning active.
- `busy` out 1: state other than IDLE.
- `fault` out 1: fill timeout occurred; sticky.

## Operation
States: IDLE, FILL, RUN_GOT, RUN_ASP, CLEAN, FAULT. All outputs are Moore-decoded from registered state.

**Internal registers**
- 8-bit `cnt`.
- `last`: last served; 0 = drip, 1 = sprinkler.
- `adb_used` flag.

**IDLE**
- No request: stay.
- Any request with `nivel < MIN_LEVEL`: go to FILL.
- Otherwise, a single request goes to its RUN state. If both requests are present, grant the one not equal to `last`.
- `cnt` clears on every transition.

**FILL**
- `VE` = 1, `cnt` increments each cycle.
- `nivel >= FULL_LEVEL`: go to IDLE.
- Else `cnt == FILL_TIMEOUT`: go to FAULT. The full check has priority when both hold.

**RUN_GOT / RUN_ASP**
- `rega` = 01 or 10. `last` updates on entry. `cnt` increments.
- In RUN_ASP, `req_adb` = 1 on any cycle sets `adb_used`.
- Exit checks, in priority order:
  1. `nivel < MIN_LEVEL`: go to FILL if own request is still high, else IDLE.
  2. Own request dropped: go to IDLE.
  3. `cnt == MAX_RUN` and the other request is high: go directly to the other RUN state, with `cnt` cleared.
- With no competitor, a run continues unbounded and `cnt` saturates at 255.
- When leaving RUN_ASP with `adb_used` = 1, go to CLEAN instead of IDLE or the other RUN state. The FILL exit still takes precedence.

**CLEAN**
- `rega` = 00, `limpeza` = 10, `VE` = 1.
- Runs for `CLEAN_CYCLES` cycles, then goes to IDLE and clears `adb_used`.
- Requests are ignored during CLEAN.

**FAULT**
- `fault` = 1; `rega` = 00, `VE` = 0, `limpeza` = 00.
- Left only by reset.

**Reset (`reset` low)**
- Immediately forces IDLE, regardless of state.
- `rega` = 00, `VE` = 0, `limpeza` = 00, `busy` = 0, `fault` = 0.
- `cnt` = 0, `last` = 1 (drip wins the first tie), `adb_used` = 0.

## Timing
- A request sampled in IDLE at edge N produces a grant visible after edge N (1-cycle latency).
- A request drop sampled at edge N removes the grant after edge N.
- Rotation: the new grant appears on the cycle after `cnt` reaches `MAX_RUN`. The old and new grants are never both asserted, and `rega` goes directly from 01 to 10 or 10 to 01.
- A FILL lasts at least 1 cycle, even if `nivel` reaches `FULL_LEVEL` on its first sampled edge.
- CLEAN lasts exactly `CLEAN_CYCLES` cycles.
- Reset assertion is asynchronous; release is sampled at the next rising edge of `clock`.

## Configuration
- `IRR_SCHED_CLEAN_EN` defined: CLEAN state and `adb_used` behave as above.
- Undefined:
  - CLEAN state is absent and `req_adb` is ignored.
  - RUN_ASP exits exactly as RUN_GOT does.
  - `limpeza` is tied to 00.

## Test plan
- Reset, `nivel` = 5, `req_got` = `req_asp` = 1 at the same edge: `rega` = 01 after 1 cycle; after 15 grant cycles `rega` = 10 with no 00 gap.
- `nivel` = 0, `req_asp` = 1: `VE` = 1; ramp `nivel` to 7: `VE` = 0 and then `rega` = 10 on the following cycle.
- `nivel` stuck at 2 during FILL: after 31 cycles `fault` = 1 and all outputs 0. Pulsing `reset` low clears `fault`.
- Sprinkler run with `req_adb` pulsed once, then `req_asp` dropped: `limpeza` = 10 and `VE` = 1 for exactly 4 cycles, then IDLE. Repeat with the macro undefined: no CLEAN phase.
- Drip run with `nivel` falling to 0 while `req_got` = 1: next state FILL, `rega` = 00, `VE` = 1.
- `reset` asserted mid-RUN_ASP between clock edges: `rega` = 00 immediately, without waiting for an edge.

Source files
------------

// File: rtl/irrigation_scheduler_if.sv
// ---------------------------------------------------------------------------
// irrigation_scheduler_if
// Bundles the request/level inputs and the irrigation status outputs of the
// irrigation scheduler.
//   req_asp  : sprinkler request, level-sensitive
//   req_got  : drip request, level-sensitive
//   req_adb  : fertilizer request, meaningful while the sprinkler is granted
//   nivel    : tank level, unsigned, LEVEL_W bits
//   rega     : granted irrigation (00 none, 01 drip, 10 sprinkler)
//   VE       : fill/flush valve open
//   limpeza  : cleaning status (00 idle, 10 cleaning)
//   busy     : scheduler not idle
//   fault    : sticky fill-timeout fault
// Modports: master drives requests and level, slave is the scheduler.
// ---------------------------------------------------------------------------
interface irrigation_scheduler_if #(
  parameter int LEVEL_W = 3
);
  logic               req_asp;
  logic               req_got;
  logic               req_adb;
  logic [LEVEL_W-1:0] nivel;
  logic [1:0]         rega;
  logic               VE;
  logic [1:0]         limpeza;
  logic               busy;
  logic               fault;

  modport master (
    output req_asp, req_got, req_adb, nivel,
    input  rega, VE, limpeza, busy, fault
  );

  modport slave (
    input  req_asp, req_got, req_adb, nivel,
    output rega, VE, limpeza, busy, fault
  );
endinterface

// File: rtl/irrigation_scheduler.sv
// ---------------------------------------------------------------------------
// irrigation_scheduler
// Shares the tank between the drip and sprinkler requesters with round-robin
// fairness, fills the tank when it is low (with a timeout fault) and, when
// built with IRR_SCHED_CLEAN_EN defined, runs a flush phase after a
// fertilized sprinkler run. Without the macro the CLEAN state does not exist,
// req_adb is ignored and limpeza is tied to 00.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : irrigation_scheduler_if.slave (requests, level, status outputs)
// All outputs are decoded from the registered state only.
// ---------------------------------------------------------------------------
module irrigation_scheduler #(
  parameter int LEVEL_W      = 3,
  parameter int MIN_LEVEL    = 1,
  parameter int FULL_LEVEL   = 7,
  parameter int MAX_RUN      = 15,
  parameter int FILL_TIMEOUT = 31,
  parameter int CLEAN_CYCLES = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  irrigation_scheduler_if.slave bus
);

  localparam logic [LEVEL_W-1:0] L_MIN     = LEVEL_W'(MIN_LEVEL);
  localparam logic [LEVEL_W-1:0] L_FULL    = LEVEL_W'(FULL_LEVEL);
  localparam logic [7:0]         L_MAX_RUN = 8'(MAX_RUN);
  localparam logic [7:0]         L_FILL_TO = 8'(FILL_TIMEOUT);
  localparam logic [7:0]         L_CLEAN   = 8'(CLEAN_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_RUN_GOT = 3'd2,
    S_RUN_ASP = 3'd3,
    S_FAULT   = 3'd4
`ifdef IRR_SCHED_CLEAN_EN
    , S_CLEAN = 3'd5
`endif
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  state_t     w_asp_leave;   // where RUN_ASP goes when it ends normally
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_inc;
  logic       r_last;        // 0 = drip served last, 1 = sprinkler
  logic       w_lvl_low;
  logic       w_lvl_full;
  logic       w_any_req;
  logic       w_rot_asp;     // sprinkler may take over from drip
  logic       w_rot_got;     // drip may take over from sprinkler

  logic [1:0] w_rega;
  logic       w_ve;
  logic [1:0] w_limpeza;
  logic       w_busy;
  logic       w_fault;

  // Saturating increment so an uncontested run can last forever.
  assign w_cnt_inc  = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
  assign w_lvl_low  = (bus.nivel < L_MIN);
  assign w_lvl_full = (bus.nivel >= L_FULL);
  assign w_any_req  = bus.req_asp | bus.req_got;
  // ">=" keeps rotation possible when the competitor shows up after the
  // run has already exceeded MAX_RUN cycles.
  assign w_rot_asp  = (w_cnt_inc >= L_MAX_RUN) & bus.req_asp;
  assign w_rot_got  = (w_cnt_inc >= L_MAX_RUN) & bus.req_got;

`ifdef IRR_SCHED_CLEAN_EN
  logic r_adb_used;
  logic w_adb_eff;

  // A fertilizer request on the very cycle the run ends still counts.
  assign w_adb_eff   = r_adb_used | bus.req_adb;
  assign w_asp_leave = w_adb_eff ? S_CLEAN : S_IDLE;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_adb_used <= 1'b0;
    end else if (r_state == S_RUN_ASP && bus.req_adb) begin
      r_adb_used <= 1'b1;
    end else if (r_state == S_CLEAN && w_state_next == S_IDLE) begin
      r_adb_used <= 1'b0;
    end
  end
`else
  logic w_unused_default;

  assign w_asp_leave      = S_IDLE;
  assign w_unused_default = bus.req_adb ^ (L_CLEAN != 8'd0);
`endif

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          if (w_lvl_low) begin
            w_state_next = S_FILL;
          end else if (bus.req_got && bus.req_asp) begin
            w_state_next = r_last ? S_RUN_GOT : S_RUN_ASP;
          end else if (bus.req_got) begin
            w_state_next = S_RUN_GOT;
          end else begin
            w_state_next = S_RUN_ASP;
          end
        end
      end
      S_FILL: begin
        if (w_lvl_full) begin
          w_state_next = S_IDLE;
        end else if (w_cnt_inc >= L_FILL_TO) begin
          w_state_next = S_FAULT;
        end
      end
      S_RUN_GOT: begin
        if (w_lvl_low) begin
          w_state_next = bus.req_got ? S_FILL : S_IDLE;
        end else if (!bus.req_got) begin
          w_state_next = S_IDLE;
        end else if (w_rot_asp) begin
          w_state_next = S_RUN_ASP;
        end
      end
      S_RUN_ASP: begin
        if (w_lvl_low) begin
          w_state_next = bus.req_asp ? S_FILL : w_asp_leave;
        end else if (!bus.req_asp) begin
          w_state_next = w_asp_leave;
        end else if (w_rot_got) begin
          // A fertilized run always flushes before handing over.
          w_state_next = (w_asp_leave == S_IDLE) ? S_RUN_GOT : w_asp_leave;
        end
      end
`ifdef IRR_SCHED_CLEAN_EN
      S_CLEAN: begin
        if (w_cnt_inc >= L_CLEAN) begin
          w_state_next = S_IDLE;
        end
      end
`endif
      S_FAULT: begin
        w_state_next = S_FAULT;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Cycle counter and round-robin pointer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt  <= 8'd0;
      r_last <= 1'b1;
    end else begin
      if (w_state_next != r_state) begin
        r_cnt <= 8'd0;
      end else if (r_state != S_IDLE && r_state != S_FAULT) begin
        r_cnt <= w_cnt_inc;
      end
      if (w_state_next == S_RUN_GOT && r_state != S_RUN_GOT) begin
        r_last <= 1'b0;
      end else if (w_state_next == S_RUN_ASP && r_state != S_RUN_ASP) begin
        r_last <= 1'b1;
      end
    end
  end

  // Moore output decode.
  always_comb begin
    w_rega    = 2'b00;
    w_ve      = 1'b0;
    w_limpeza = 2'b00;
    w_fault   = 1'b0;
    w_busy    = (r_state != S_IDLE);
    case (r_state)
      S_FILL:    w_ve   = 1'b1;
      S_RUN_GOT: w_rega = 2'b01;
      S_RUN_ASP: w_rega = 2'b10;
`ifdef IRR_SCHED_CLEAN_EN
      S_CLEAN: begin
        w_ve      = 1'b1;
        w_limpeza = 2'b10;
      end
`endif
      S_FAULT:   w_fault = 1'b1;
      default:   w_rega  = 2'b00;
    endcase
  end

  assign bus.rega    = w_rega;
  assign bus.VE      = w_ve;
  assign bus.limpeza = w_limpeza;
  assign bus.busy    = w_busy;
  assign bus.fault   = w_fault;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// ---------------------------------------------------------------------------
// tb_irrigation_scheduler
// Self-checking bench for irrigation_scheduler: a vector table of per-cycle
// inputs and expected outputs, plus hand-written sequences for rotation,
// fill timeout and asynchronous reset. Expected outputs go into a queue when
// inputs are driven and are popped when the outputs are sampled.
// Expectations follow IRR_SCHED_CLEAN_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_irrigation_scheduler;
  localparam int LEVEL_W = 3;
`ifdef IRR_SCHED_CLEAN_EN
  localparam bit CLEAN_EN = 1'b1;
`else
  localparam bit CLEAN_EN = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] rega;
    logic       ve;
    logic [1:0] limp;
    logic       busy;
    logic       fault;
  } outs_t;

  typedef struct {
    bit          rst;
    logic        got;
    logic        asp;
    logic        adb;
    logic [2:0]  nivel;
    outs_t       exp;
    string       name;
  } vec_t;

  logic  clock = 1'b0;
  logic  reset = 1'b0;
  int    n_tests = 0;
  int    n_fail  = 0;
  vec_t  vecs[$];
  outs_t sb_q[$];
  string sb_name[$];

  irrigation_scheduler_if #(.LEVEL_W(LEVEL_W)) bus ();

  irrigation_scheduler #(
    .LEVEL_W(LEVEL_W), .MIN_LEVEL(1), .FULL_LEVEL(7), .MAX_RUN(15),
    .FILL_TIMEOUT(31), .CLEAN_CYCLES(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  function automatic outs_t o(input logic [1:0] r, input logic v,
                              input logic [1:0] l, input logic b,
                              input logic f);
    outs_t t;
    t.rega = r; t.ve = v; t.limp = l; t.busy = b; t.fault = f;
    return t;
  endfunction

  // After a fertilized sprinkler run ends: cleaning if built in, else idle.
  function automatic outs_t after_adb();
    return CLEAN_EN ? o(2'b00, 1'b1, 2'b10, 1'b1, 1'b0)
                    : o(2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
  endfunction

  function automatic void add(input bit rst, input logic got, input logic asp,
                              input logic adb, input logic [2:0] nv,
                              input outs_t exp, input string nm);
    vec_t v;
    v.rst = rst; v.got = got; v.asp = asp; v.adb = adb;
    v.nivel = nv; v.exp = exp; v.name = nm;
    vecs.push_back(v);
  endfunction

  // Pop the oldest expectation and compare it with the current outputs.
  task automatic check_out();
    outs_t act, exp;
    string nm;
    act = {bus.rega, bus.VE, bus.limpeza, bus.busy, bus.fault};
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got outputs=%b, no expectation queued", act);
      return;
    end
    exp = sb_q.pop_front();
    nm  = sb_name.pop_front();
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got rega=%b VE=%b limpeza=%b busy=%b fault=%b, expected rega=%b VE=%b limpeza=%b busy=%b fault=%b",
               nm, act.rega, act.ve, act.limp, act.busy, act.fault,
               exp.rega, exp.ve, exp.limp, exp.busy, exp.fault);
    end else begin
      $display("[TB] %s: rega=%b VE=%b limpeza=%b busy=%b fault=%b ok",
               nm, act.rega, act.ve, act.limp, act.busy, act.fault);
    end
  endtask

  task automatic drive(input logic got, input logic asp, input logic adb,
                       input logic [2:0] nv, input outs_t exp, input string nm);
    bus.req_got = got;
    bus.req_asp = asp;
    bus.req_adb = adb;
    bus.nivel   = nv;
    sb_q.push_back(exp);
    sb_name.push_back(nm);
    @(posedge clock);
    #1;
    check_out();
  endtask

  // Reset for one edge, check the reset outputs, release before next edge.
  task automatic do_reset();
    reset       = 1'b0;
    bus.req_got = 1'b0;
    bus.req_asp = 1'b0;
    bus.req_adb = 1'b0;
    bus.nivel   = 3'd0;
    sb_q.push_back(o(2'b00, 1'b0, 2'b00, 1'b0, 1'b0));
    sb_name.push_back("reset_state");
    @(posedge clock);
    #1;
    check_out();
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  initial begin
    outs_t idle_o, fill_o, got_o, asp_o, fault_o;
    idle_o  = o(2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
    fill_o  = o(2'b00, 1'b1, 2'b00, 1'b1, 1'b0);
    got_o   = o(2'b01, 1'b0, 2'b00, 1'b1, 1'b0);
    asp_o   = o(2'b10, 1'b0, 2'b00, 1'b1, 1'b0);
    fault_o = o(2'b00, 1'b0, 2'b00, 1'b1, 1'b1);

    // Fill then sprinkler run with fertilizer, then flush (if built in).
    add(1, 0, 1, 0, 3'd0, fill_o,      "A_fill_enter");
    add(0, 0, 1, 0, 3'd3, fill_o,      "A_fill_hold");
    add(0, 0, 1, 0, 3'd7, idle_o,      "A_fill_full");
    add(0, 0, 1, 0, 3'd7, asp_o,       "A_asp_grant");
    add(0, 0, 1, 1, 3'd7, asp_o,       "A_asp_adb");
    add(0, 0, 1, 0, 3'd7, asp_o,       "A_asp_hold");
    add(0, 0, 0, 0, 3'd7, after_adb(), "A_clean1");
    add(0, 0, 0, 0, 3'd7, after_adb(), "A_clean2");
    add(0, 0, 0, 0, 3'd7, after_adb(), "A_clean3");
    add(0, 0, 0, 0, 3'd7, after_adb(), "A_clean4");
    add(0, 0, 0, 0, 3'd7, idle_o,      "A_clean_done");
    // Drip run, level boundary, low level with request held, round robin.
    add(1, 1, 0, 0, 3'd5, got_o,       "B_got_grant");
    add(0, 1, 0, 0, 3'd1, got_o,       "B_got_min_level");
    add(0, 1, 0, 0, 3'd0, fill_o,      "B_got_low_fill");
    add(0, 1, 0, 0, 3'd7, idle_o,      "B_fill_one_cycle");
    add(0, 1, 0, 0, 3'd7, got_o,       "B_got_regrant");
    add(0, 0, 0, 0, 3'd0, idle_o,      "B_got_low_dropped");
    add(0, 1, 1, 0, 3'd5, asp_o,       "B_tie_after_drip");
    add(0, 1, 1, 0, 3'd5, asp_o,       "B_asp_hold");
    add(0, 1, 0, 0, 3'd5, idle_o,      "B_asp_dropped");
    add(0, 1, 0, 0, 3'd1, got_o,       "B_idle_min_level");
    add(0, 0, 0, 0, 3'd1, idle_o,      "B_got_dropped");
    // Fertilized sprinkler loses level: FILL wins over cleaning.
    add(1, 0, 1, 0, 3'd5, asp_o,       "C_asp_grant");
    add(0, 0, 1, 1, 3'd5, asp_o,       "C_asp_adb");
    add(0, 0, 1, 0, 3'd0, fill_o,      "C_asp_low_fill");
    add(0, 0, 1, 0, 3'd7, idle_o,      "C_fill_full");
    add(0, 0, 1, 0, 3'd7, asp_o,       "C_asp_regrant");
    add(0, 0, 0, 0, 3'd7, after_adb(), "C_clean1");
    add(0, 0, 0, 0, 3'd7, after_adb(), "C_clean2");
    add(0, 0, 0, 0, 3'd7, after_adb(), "C_clean3");
    add(0, 0, 0, 0, 3'd7, after_adb(), "C_clean4");
    add(0, 0, 0, 0, 3'd7, idle_o,      "C_clean_done");

    reset       = 1'b0;
    bus.req_got = 1'b0;
    bus.req_asp = 1'b0;
    bus.req_adb = 1'b0;
    bus.nivel   = 3'd0;
    #12;

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      drive(vecs[i].got, vecs[i].asp, vecs[i].adb, vecs[i].nivel,
            vecs[i].exp, vecs[i].name);
    end

    // Simultaneous requests after reset: drip first, rotate after 15 cycles.
    do_reset();
    for (int k = 0; k < 15; k++) drive(1, 1, 0, 3'd5, got_o, "rot_got_phase");
    for (int k = 0; k < 15; k++) drive(1, 1, 0, 3'd5, asp_o, "rot_asp_phase");
    drive(1, 1, 0, 3'd5, got_o,  "rot_back_to_got");
    drive(0, 0, 0, 3'd5, idle_o, "rot_release");

    // Fill timeout: level stuck at 2 for 31 fill cycles, fault is sticky.
    do_reset();
    drive(0, 1, 0, 3'd0, fill_o, "to_fill_enter");
    for (int k = 0; k < 30; k++) drive(0, 1, 0, 3'd2, fill_o, "to_fill_wait");
    drive(0, 1, 0, 3'd2, fault_o, "to_fault");
    for (int k = 0; k < 3; k++) drive(1, 1, 1, 3'd7, fault_o, "to_fault_sticky");
    do_reset();
    drive(1, 0, 0, 3'd5, got_o, "to_after_reset_run");

    // Asynchronous reset between edges during a sprinkler run.
    do_reset();
    drive(0, 1, 0, 3'd5, asp_o, "ar_asp_grant");
    #2;
    reset = 1'b0;
    #1;
    sb_q.push_back(idle_o);
    sb_name.push_back("ar_async_clear");
    check_out();
    @(posedge clock);
    #1;
    sb_q.push_back(idle_o);
    sb_name.push_back("ar_held_in_reset");
    check_out();
    reset = 1'b1;
    drive(0, 1, 0, 3'd5, asp_o, "ar_resume");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
